// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
// Contents: word width, default storage depth, FSM state encoding, and the
// address legality check (word alignment plus range against the storage depth).
package mem_pkg;

   localparam int unsigned WORD_W             = 32;
   localparam int unsigned DEFAULT_DEPTH_LOG2 = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // True when addr is word aligned and its word index fits in 2**depth_log2 words.
   function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                    input int unsigned depth_log2);
      logic [WORD_W-1:0] w_hi;
      w_hi = addr >> (depth_log2 + 2);
      return (addr[1:0] == 2'b00) && (w_hi == '0);
   endfunction

endpackage

// File: rtl/responder_ram.sv
// Single-port word storage for the memory responder.
// Ports:
//   i_clk   - rising-edge clock
//   i_rst_n - async active-low reset (read register only; storage is not cleared)
//   i_en    - access enable for this edge
//   i_we    - 1 = write i_wd to i_addr, 0 = load o_rd from i_addr
//   i_addr  - word index
//   i_wd    - write data
//   o_rd    - registered read data, changes only on an enabled read
module responder_ram #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wd,
   output logic [DATA_W-1:0] o_rd
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd;

   always_ff @(posedge i_clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wd;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd <= '0;
      end else if (i_en && !i_we) begin
         r_rd <= r_mem[i_addr];
      end
   end

   assign o_rd = r_rd;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states.
// Accepts one word read/write at a time, stalls WAIT_STATES extra cycles, then
// pulses Ready for one cycle. Misaligned or out-of-range addresses skip storage
// and respond next cycle with Err=1 and RD=0.
// Ports:
//   Clk     - rising-edge clock
//   Reset_n - async active-low reset
//   Req     - request valid, sampled only in IDLE
//   WE      - 1 = write, 0 = read (latched with Req)
//   A       - byte address (latched with Req)
//   WD      - write data (latched with Req)
//   RD      - read data, valid while Ready=1 and Err=0
//   Ready   - one-cycle completion pulse
//   Err     - error qualifier, valid with Ready
//   Busy    - high whenever not IDLE
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Req,
   input  logic              WE,
   input  logic [WORD_W-1:0] A,
   input  logic [WORD_W-1:0] WD,
   output logic [WORD_W-1:0] RD,
   output logic              Ready,
   output logic              Err,
   output logic              Busy
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   state_e                  r_state, w_state_d;
   logic [3:0]              r_cnt, w_cnt_d;
   logic                    r_we;
   logic [DEPTH_LOG2-1:0]   r_idx;
   logic [WORD_W-1:0]       r_wd;
   logic                    r_err, w_err_d;
   // Forces RD to zero after an error until the next read commit replaces it.
   logic                    r_rd_zero, w_rd_zero_d;
   logic                    w_accept;
   logic                    w_commit;
   logic                    w_addr_ok;
   logic [WORD_W-1:0]       w_ram_rd;

   assign w_addr_ok = addr_ok(A, DEPTH_LOG2);

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_err_d     = r_err;
      w_rd_zero_d = r_rd_zero;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (Req) begin
               w_accept = 1'b1;
               if (w_addr_ok) begin
                  w_state_d = ST_ACCESS;
                  w_cnt_d   = WAIT_CNT;
               end else begin
                  w_state_d   = ST_RESP;
                  w_err_d     = 1'b1;
                  w_rd_zero_d = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (r_cnt != 4'd0) begin
               w_cnt_d = r_cnt - 4'd1;
            end else begin
               w_commit  = 1'b1;
               w_state_d = ST_RESP;
               w_err_d   = 1'b0;
               if (!r_we) begin
                  w_rd_zero_d = 1'b0;
               end
            end
         end
         ST_RESP: begin
            w_state_d = ST_IDLE;
            w_err_d   = 1'b0;
         end
         default: begin
            w_state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_err     <= 1'b0;
         r_rd_zero <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_err     <= w_err_d;
         r_rd_zero <= w_rd_zero_d;
      end
   end

   // Request fields are captured only on acceptance, so later input changes are ignored.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_we  <= 1'b0;
         r_idx <= '0;
         r_wd  <= '0;
      end else if (w_accept) begin
         r_we  <= WE;
         r_idx <= A[DEPTH_LOG2+1:2];
         r_wd  <= WD;
      end
   end

   responder_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (WORD_W)
   ) u_ram (
      .i_clk   (Clk),
      .i_rst_n (Reset_n),
      .i_en    (w_commit),
      .i_we    (r_we),
      .i_addr  (r_idx),
      .i_wd    (r_wd),
      .o_rd    (w_ram_rd)
   );

   assign RD    = r_rd_zero ? '0 : w_ram_rd;
   assign Ready = (r_state == ST_RESP);
   assign Err   = r_err;
   assign Busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances (WAIT_STATES=2 and 0)
// share one stimulus stream; each has a transaction-timeline model and a
// per-cycle compare process. Directed sequences pin literal expectations,
// then a randomized phase (including reset pulses) runs against the models.
module tb_mem_responder;

   localparam int unsigned NDUT = 2;

   logic        Clk     = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Req     = 1'b0;
   logic        WE      = 1'b0;
   logic [31:0] A       = '0;
   logic [31:0] WD      = '0;

   logic [31:0] rd_o    [NDUT];
   logic        ready_o [NDUT];
   logic        err_o   [NDUT];
   logic        busy_o  [NDUT];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   int          lat_q [NDUT];
   logic [31:0] rdq   [NDUT];
   logic        errq  [NDUT];

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         localparam int unsigned WS = (g == 0) ? 2 : 0;

         logic [31:0] w_rd;
         logic        w_ready, w_err, w_busy;

         mem_responder #(
            .DEPTH_LOG2  (6),
            .WAIT_STATES (WS)
         ) u_dut (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .Req     (Req),
            .WE      (WE),
            .A       (A),
            .WD      (WD),
            .RD      (w_rd),
            .Ready   (w_ready),
            .Err     (w_err),
            .Busy    (w_busy)
         );

         assign rd_o[g]    = w_rd;
         assign ready_o[g] = w_ready;
         assign err_o[g]   = w_err;
         assign busy_o[g]  = w_busy;

         // Model: one outstanding transaction described by its accept and
         // response cycle numbers; storage is a plain array.
         int unsigned cyc     = 0;
         bit          p_valid = 1'b0;
         int unsigned p_acc   = 0;
         int unsigned p_resp  = 0;
         bit          p_err   = 1'b0;
         bit          p_we    = 1'b0;
         int unsigned p_idx   = 0;
         logic [31:0] p_wd    = '0;
         logic [31:0] exp_rd  = '0;
         logic [31:0] m_mem [64];

         initial begin : model_p
            int unsigned k;
            bit          ok;
            forever begin
               @(posedge Clk or negedge Reset_n);
               if (!Reset_n) begin
                  p_valid = 1'b0;
                  exp_rd  = '0;
               end else begin
                  k = cyc;
                  if (p_valid && !p_err && (k + 1 == p_resp)) begin
                     if (p_we) m_mem[p_idx] = p_wd;
                     else      exp_rd = m_mem[p_idx];
                  end
                  if ((!p_valid || k > p_resp) && Req) begin
                     ok      = (A % 4 == 0) && ((A / 4) < 64);
                     p_valid = 1'b1;
                     p_acc   = k;
                     p_err   = !ok;
                     p_we    = WE;
                     p_idx   = (A / 4) % 64;
                     p_wd    = WD;
                     p_resp  = ok ? k + WS + 2 : k + 1;
                     if (!ok) exp_rd = '0;
                  end
                  cyc = k + 1;
               end
            end
         end

         initial begin : compare_p
            int unsigned k;
            bit          e_ready, e_busy, e_err;
            @(posedge Clk);
            forever begin
               @(negedge Clk);
               k       = cyc;
               e_ready = p_valid && (k == p_resp);
               e_busy  = p_valid && (k > p_acc) && (k <= p_resp);
               e_err   = e_ready && p_err;
               check($sformatf("dut%0d busy c%0d", g, k), 32'(w_busy), 32'(e_busy));
               check($sformatf("dut%0d ready c%0d", g, k), 32'(w_ready), 32'(e_ready));
               check($sformatf("dut%0d err c%0d", g, k), 32'(w_err), 32'(e_err));
               check($sformatf("dut%0d rd c%0d", g, k), w_rd, exp_rd);
            end
         end
      end
   endgenerate

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge Clk);
      while ((busy_o[0] || busy_o[1]) && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle wait: got busy after 50 cycles, required idle");
      end
   endtask

   // One request; records per-instance latency and the RD/Err seen with Ready.
   // Inputs are scrambled right after acceptance to show they are ignored.
   task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd);
      bit done [NDUT];
      wait_idle();
      #1;
      Req = 1'b1;
      WE  = we;
      A   = a;
      WD  = wd;
      for (int i = 0; i < NDUT; i++) begin
         done[i]  = 1'b0;
         lat_q[i] = -1;
      end
      for (int n = 1; n <= 40; n++) begin
         @(negedge Clk);
         for (int i = 0; i < NDUT; i++) begin
            if (!done[i] && ready_o[i]) begin
               lat_q[i] = n;
               rdq[i]   = rd_o[i];
               errq[i]  = err_o[i];
               done[i]  = 1'b1;
            end
         end
         if (n == 1) begin
            #1;
            Req = 1'b0;
            A   = $urandom;
            WD  = $urandom;
            WE  = 1'($urandom);
         end
         if (done[0] && done[1]) break;
      end
      if (!(done[0] && done[1])) begin
         n_cmp++;
         n_bad++;
         $display("FAIL response wait: got no Ready within 40 cycles, required Ready");
      end
   endtask

   task automatic chk_x(input string name, input int l0, input int l1,
                        input logic e_err, input bit chk_rd, input logic [31:0] e_rd);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("%s lat dut%0d", name, i), 32'(lat_q[i]), 32'((i == 0) ? l0 : l1));
         check($sformatf("%s err dut%0d", name, i), 32'(errq[i]), 32'(e_err));
         if (chk_rd) check($sformatf("%s rd dut%0d", name, i), rdq[i], e_rd);
      end
   endtask

   initial begin : main_p
      int r0, r1, idle1, rdy;
      logic [31:0] init_w;

      // Reset held with a pending request.
      Reset_n = 1'b0;
      Req     = 1'b1;
      WE      = 1'b1;
      A       = 32'h0;
      WD      = 32'hA000_5A5A;
      repeat (3) @(negedge Clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("reset rd dut%0d", i), rd_o[i], 32'h0);
         check($sformatf("reset ready dut%0d", i), 32'(ready_o[i]), 32'h0);
         check($sformatf("reset err dut%0d", i), 32'(err_o[i]), 32'h0);
         check($sformatf("reset busy dut%0d", i), 32'(busy_o[i]), 32'h0);
      end
      #1 Reset_n = 1'b1;
      @(negedge Clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("first accept busy dut%0d", i), 32'(busy_o[i]), 32'h1);
      end
      #1 Req = 1'b0;

      // Fill every word with a known pattern.
      for (int w = 1; w < 64; w++) begin
         init_w = {8'hA0, 8'(w), 16'h5A5A};
         xact(1'b1, 32'(w * 4), init_w);
      end

      xact(1'b0, 32'h4, 32'h0);
      chk_x("read 0x4", 4, 2, 1'b0, 1'b1, 32'hA001_5A5A);
      xact(1'b1, 32'h8, 32'hDEAD_BEEF);
      chk_x("write 0x8", 4, 2, 1'b0, 1'b1, 32'hA001_5A5A);
      xact(1'b0, 32'h8, 32'h0);
      chk_x("read 0x8", 4, 2, 1'b0, 1'b1, 32'hDEAD_BEEF);
      xact(1'b1, 32'h6, 32'hBAD0_BAD0);
      chk_x("misaligned 0x6", 1, 1, 1'b1, 1'b1, 32'h0);
      xact(1'b0, 32'h4, 32'h0);
      chk_x("reread 0x4", 4, 2, 1'b0, 1'b1, 32'hA001_5A5A);
      xact(1'b1, 32'h100, 32'h1111_2222);
      chk_x("range 0x100", 1, 1, 1'b1, 1'b1, 32'h0);

      // Reset in the first ACCESS cycle of a write to 0xC.
      wait_idle();
      #1;
      Req = 1'b1;
      WE  = 1'b1;
      A   = 32'hC;
      WD  = 32'h1234_5678;
      @(negedge Clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("abort accepted busy dut%0d", i), 32'(busy_o[i]), 32'h1);
      end
      #1;
      Req     = 1'b0;
      Reset_n = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("abort reset busy dut%0d", i), 32'(busy_o[i]), 32'h0);
      end
      #1 Reset_n = 1'b1;
      rdy = 0;
      repeat (6) begin
         @(negedge Clk);
         if (ready_o[0] || ready_o[1]) rdy++;
      end
      check("abort no ready", 32'(rdy), 32'h0);
      xact(1'b0, 32'hC, 32'h0);
      chk_x("read 0xC after abort", 4, 2, 1'b0, 1'b1, 32'hA003_5A5A);

      // Input stability: xact scrambles A/WD/WE during ACCESS.
      xact(1'b1, 32'h10, 32'hCAFE_F00D);
      chk_x("write 0x10", 4, 2, 1'b0, 1'b0, 32'h0);
      xact(1'b0, 32'h10, 32'h0);
      chk_x("read 0x10", 4, 2, 1'b0, 1'b1, 32'hCAFE_F00D);

      // Back-to-back with Req held and A alternating 0x0 / 0x4.
      wait_idle();
      #1;
      Req = 1'b1;
      WE  = 1'b0;
      A   = 32'h0;
      r0 = 0; r1 = 0; idle1 = 0;
      for (int n = 1; n <= 24; n++) begin
         @(negedge Clk);
         if (ready_o[0]) r0++;
         if (ready_o[1]) r1++;
         if (!busy_o[1]) idle1++;
         #1 A = (n % 2 == 1) ? 32'h4 : 32'h0;
      end
      Req = 1'b0;
      check("b2b ready count ws2", 32'(r0), 32'd5);
      check("b2b ready count ws0", 32'(r1), 32'd8);
      check("b2b idle count ws0", 32'(idle1), 32'd8);

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         @(negedge Clk);
         #1;
         Reset_n = ($urandom_range(0, 399) != 0);
         Req     = ($urandom_range(0, 3) != 0);
         WE      = 1'($urandom);
         WD      = $urandom;
         case ($urandom_range(0, 7))
            0:       A = $urandom;
            1:       A = {$urandom_range(1, 255), 8'h00};
            2:       A = 32'($urandom_range(0, 255)) | 32'h1;
            default: A = 32'($urandom_range(0, 63)) << 2;
         endcase
      end
      @(negedge Clk);
      #1;
      Req     = 1'b0;
      Reset_n = 1'b1;
      repeat (12) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's shared instruction/data memory port.
- Accepts one word request at a time (read or write) over a Req/Ready handshake.
- Inserts a programmable number of wait states to model slow memory, then responds.
- Flags misaligned or out-of-range addresses instead of accessing storage.
- Replaces the zero-latency asynchronous memory so that the controller FSM can be exercised with stall cycles.

Parameters:
- DEPTH_LOG2, 6, log2 of storage depth in 32-bit words (default 64 words).
- WAIT_STATES, 2, extra cycles spent in ACCESS before the operation commits (0..15).

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Req  in  1  request valid; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; latched with Req.
- A  in  32  byte address; latched with Req.
- WD  in  32  write data; latched with Req.
- RD  out  32  read data; valid while Ready=1 and Err=0.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  error qualifier, valid with Ready.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values: state=IDLE, RD=0, Ready=0, Err=0, Busy=0, wait counter=0. The storage array is not cleared.
- States: IDLE, ACCESS, RESP (2-bit encoding 00/01/10).
- IDLE:
  - If Req=1 at an edge, latch WE, A and WD.
  - If A[1:0]!=0 or A[31:2] >= 2^DEPTH_LOG2, go to RESP with Err=1.
  - Otherwise load counter=WAIT_STATES and go to ACCESS.
- ACCESS, counter != 0: decrement the counter and stay.
- ACCESS, counter == 0, at the edge:
  - If WE, write the latched WD to word A[DEPTH_LOG2+1:2].
  - Otherwise load RD from that word.
  - Go to RESP with Err=0.
- RESP:
  - Ready=1 for exactly one cycle, then return to IDLE.
  - Err is cleared on leaving RESP.
  - If Req is still high in IDLE, it is a new request; the requester must drop Req during RESP to avoid a repeat.
- Latency:
  - Req accepted at the end of cycle c gives Ready=1 in cycle c+WAIT_STATES+2.
  - An error response has Ready=1 in cycle c+1.
- RD behaviour:
  - RD changes only on read commit or on an error, where it is forced to 0.
  - RD is unchanged on write completion.
- Inputs in ACCESS/RESP: changes to A, WD, WE and Req are ignored. There is no cancel; dropping Req mid-access does not abort the operation.
- Read-after-write to the same word must return the new data. This holds because a write commits at its ACCESS edge, before any later request is accepted.
- Reset mid-operation: return to IDLE immediately. An uncommitted write is discarded and storage is unchanged; Ready is never emitted for the aborted request.
- Error requests never modify storage, even if WE=1.
- Counter width is 4 bits. WAIT_STATES=0 means a single ACCESS cycle.

Decomposition:
- Shared package mem_pkg:
  - state encodings ST_IDLE, ST_ACCESS, ST_RESP;
  - WORD_W=32;
  - default DEPTH_LOG2;
  - a function that checks alignment and range.
- Sub-module responder_ram:
  - word array, synchronous write and synchronous registered read, single port;
  - enable/we/addr/wd/rd ports, driven only from the ACCESS commit edge.
- The FSM, counter and error logic stay in mem_responder.

Test Plan:
- Reset: hold Reset_n=0 with Req=1 -> RD=0, Ready=0, Err=0, Busy=0. Release -> IDLE, first request is accepted.
- Write then read, WAIT_STATES=2:
  - write A=0x0000_0008, WD=0xDEAD_BEEF -> Ready after 4 cycles with Err=0 and RD unchanged;
  - read A=0x8 -> Ready after 4 cycles with RD=0xDEAD_BEEF.
- Misaligned and out-of-range:
  - write A=0x0000_0006 -> Ready next cycle with Err=1, RD=0; a subsequent read of 0x4 shows its prior value;
  - A=0x0000_0100 (word 64) -> Err=1.
- Reset during ACCESS: write 0x1234_5678 to 0xC, assert Reset_n=0 in the first ACCESS cycle -> no Ready pulse; a later read of 0xC returns the old data.
- Back-to-back with WAIT_STATES=0: Req held high continuously alternating read 0x0 and read 0x4 -> Ready every 3rd cycle, Busy low exactly one cycle between requests, RD matches each word.
- Input stability: change A and WD during ACCESS of a write to 0x10 -> the latched values are the ones written; a read of 0x10 confirms this.
